// File: rtl/chip8_rand_pkg.sv
// Shared types and constants for the CXNN random byte unit.
// CHIP8_RAND_MIX_EN (optional) enables the extra mix register in the top.
package chip8_rand_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } rand_state_t;

  localparam logic [7:0] MIX_SEED      = 8'hA5;
  localparam int         DEFAULT_DEPTH = 4;
  localparam int         DEFAULT_DECIM = 3;

  function automatic logic [7:0] fold(input logic [15:0] word);
    return word[15:8] ^ word[7:0];
  endfunction

endpackage

// File: rtl/chip8_rand_fifo.sv
// Synchronous DEPTH x 8 circular prefetch FIFO; head is read combinationally
// so the consumer can pop and capture it at the same edge.
module chip8_rand_fifo
  import chip8_rand_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem[rd_ptr_q];
  assign level = count_q;

  // A push into a full FIFO is only legal when the head leaves at the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/chip8_rand_byte_unit.sv
// Folds the LFSR word to a byte, decimates it into a prefetch FIFO and serves
// CXNN req/ack requests. Optional macro CHIP8_RAND_MIX_EN adds a mix register.
module chip8_rand_byte_unit
  import chip8_rand_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DECIM = DEFAULT_DECIM
) (
  input  logic                   cpu_clk,
  input  logic                   reset,
  input  logic [15:0]            rand_num,
  input  logic                   req,
  input  logic [7:0]             mask,
  output logic                   ack,
  output logic [7:0]             rand_byte,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  rand_state_t   state_q, state_d;
  logic [CW-1:0] decim_cnt_q, decim_cnt_d;
  logic [7:0]    rand_byte_q, rand_byte_d;
  logic          decim_hit;
  logic          push, pop;
  logic [7:0]    head;
  logic          full, empty;
`ifdef CHIP8_RAND_MIX_EN
  logic [7:0]    mix_q, mix_d;
`endif

  chip8_rand_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (cpu_clk),
    .srst  (reset),
    .push  (push),
    .pop   (pop),
    .wdata (fold(rand_num)),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // The decimation counter free-runs so the fill cadence never depends on demand.
  assign decim_hit = (decim_cnt_q == CW'(DECIM - 1));
  assign push      = decim_hit && (!full || pop);

  always_comb begin
    decim_cnt_d = decim_hit ? '0 : decim_cnt_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rand_byte_d = rand_byte_q;
    pop         = 1'b0;
`ifdef CHIP8_RAND_MIX_EN
    mix_d       = mix_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          pop     = !empty;
          state_d = empty ? WAIT : ACK;
        end
      end
      WAIT: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (pop) begin
`ifdef CHIP8_RAND_MIX_EN
      rand_byte_d = (head ^ mix_q) & mask;
      mix_d       = {mix_q[6:0], mix_q[7]} ^ head;
`else
      rand_byte_d = head & mask;
`endif
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      decim_cnt_q <= '0;
      rand_byte_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      decim_cnt_q <= decim_cnt_d;
      rand_byte_q <= rand_byte_d;
    end
  end

`ifdef CHIP8_RAND_MIX_EN
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      mix_q <= MIX_SEED;
    end else begin
      mix_q <= mix_d;
    end
  end
`endif

  assign ack       = (state_q == ACK);
  assign rand_byte = rand_byte_q;

  // The CPU must hold req until it is served.
  a_req_held_in_wait: assert property (
    @(posedge cpu_clk) disable iff (reset) (state_q == WAIT) |-> req
  );

endmodule

// File: tb/tb_chip8_rand_byte_unit.sv
// Directed self-checking bench for chip8_rand_byte_unit (DEPTH=4, DECIM=3).
module tb_chip8_rand_byte_unit;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic [15:0] rand_num;
  logic        req;
  logic [7:0]  mask;
  logic        ack;
  logic [7:0]  rand_byte;
  logic [2:0]  fifo_level;

  int checks   = 0;
  int failures = 0;

`ifdef CHIP8_RAND_MIX_EN
  localparam logic [7:0] EMPTY_B = 8'h82;  // (27^A5)&FF, mix -> 6C
  localparam logic [7:0] NOBYP_B = 8'h4B;  // (27^6C)&FF
  localparam logic [7:0] HIT_B   = 8'h02;  // (27^A5)&0F, mix -> 6C
  localparam logic [7:0] B2B_B0  = 8'hD8;  // mix FF after collision pop
  localparam logic [7:0] B2B_B1  = 8'hFF;  // mix D8
`else
  localparam logic [7:0] EMPTY_B = 8'h27;
  localparam logic [7:0] NOBYP_B = 8'h27;
  localparam logic [7:0] HIT_B   = 8'h07;
  localparam logic [7:0] B2B_B0  = 8'h27;
  localparam logic [7:0] B2B_B1  = 8'h27;
`endif

  chip8_rand_byte_unit dut (
    .cpu_clk    (cpu_clk),
    .reset      (reset),
    .rand_num   (rand_num),
    .req        (req),
    .mask       (mask),
    .ack        (ack),
    .rand_byte  (rand_byte),
    .fifo_level (fifo_level)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 1'b0;
    mask  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ack, rand_byte, fifo_level} !== {1'b0, 8'h00, 3'd0}) begin
      failures++;
      $display("FAIL reset got ack=%b byte=%h lvl=%0d exp ack=0 byte=00 lvl=0", ack, rand_byte, fifo_level);
    end else $display("reset ok");
  endtask

  // Pushes land on edges 3,6,9,12; level saturates at 4.
  task automatic test_fill();
    logic [2:0] exp_lvl;
    for (int e = 1; e <= 15; e++) begin
      tick();
      exp_lvl = (e / 3 > 4) ? 3'd4 : 3'(e / 3);
      checks++;
      if ({ack, fifo_level} !== {1'b0, exp_lvl}) begin
        failures++;
        $display("FAIL fill_e%0d got ack=%b lvl=%0d exp ack=0 lvl=%0d", e, ack, fifo_level, exp_lvl);
      end else $display("fill edge %0d lvl=%0d", e, fifo_level);
    end
  endtask

  // Continues from edge 15 (full). Edge 16 is not a decim edge.
  task automatic test_hit();
    req = 1'b1; mask = 8'h0F;
    tick();  // edge 16
    req = 1'b0;
    checks++;
    if ({ack, rand_byte, fifo_level} !== {1'b1, HIT_B, 3'd3}) begin
      failures++;
      $display("FAIL hit_ack got ack=%b byte=%h lvl=%0d exp ack=1 byte=%h lvl=3", ack, rand_byte, fifo_level, HIT_B);
    end else $display("hit ack byte=%h", rand_byte);
    tick();  // edge 17
    checks++;
    if ({ack, rand_byte, fifo_level} !== {1'b0, HIT_B, 3'd3}) begin
      failures++;
      $display("FAIL hit_after got ack=%b byte=%h lvl=%0d exp ack=0 byte=%h lvl=3", ack, rand_byte, fifo_level, HIT_B);
    end else $display("hit after ack low");
    tick();  // edge 18: refill
    checks++;
    if (fifo_level !== 3'd4) begin
      failures++;
      $display("FAIL hit_refill got lvl=%0d exp lvl=4", fifo_level);
    end else $display("hit refill lvl=4");
  endtask

  // Full FIFO, pop coincides with the decim push on edge 21.
  task automatic test_full_collision();
    tick();  // edge 19
    tick();  // edge 20
    req = 1'b1; mask = 8'h00;
    tick();  // edge 21
    req = 1'b0;
    checks++;
    if ({ack, rand_byte, fifo_level} !== {1'b1, 8'h00, 3'd4}) begin
      failures++;
      $display("FAIL collision got ack=%b byte=%h lvl=%0d exp ack=1 byte=00 lvl=4", ack, rand_byte, fifo_level);
    end else $display("collision ack byte=%h lvl=%0d", rand_byte, fifo_level);
    tick();  // edge 22
    checks++;
    if ({ack, fifo_level} !== {1'b0, 3'd4}) begin
      failures++;
      $display("FAIL collision_after got ack=%b lvl=%0d exp ack=0 lvl=4", ack, fifo_level);
    end else $display("collision after lvl=4");
  endtask

  // Held req: one ack per two cycles.
  task automatic test_back_to_back();
    req = 1'b1; mask = 8'hFF;
    tick();  // edge 23: pop
    checks++;
    if ({ack, rand_byte, fifo_level} !== {1'b1, B2B_B0, 3'd3}) begin
      failures++;
      $display("FAIL b2b_0 got ack=%b byte=%h lvl=%0d exp ack=1 byte=%h lvl=3", ack, rand_byte, fifo_level, B2B_B0);
    end else $display("b2b ack0 byte=%h", rand_byte);
    tick();  // edge 24: ACK->IDLE, decim push
    checks++;
    if ({ack, fifo_level} !== {1'b0, 3'd4}) begin
      failures++;
      $display("FAIL b2b_gap got ack=%b lvl=%0d exp ack=0 lvl=4", ack, fifo_level);
    end else $display("b2b gap");
    tick();  // edge 25: pop
    req = 1'b0;
    checks++;
    if ({ack, rand_byte, fifo_level} !== {1'b1, B2B_B1, 3'd3}) begin
      failures++;
      $display("FAIL b2b_1 got ack=%b byte=%h lvl=%0d exp ack=1 byte=%h lvl=3", ack, rand_byte, fifo_level, B2B_B1);
    end else $display("b2b ack1 byte=%h", rand_byte);
  endtask

  // req right after reset with empty FIFO: WAIT, served at edge 4.
  task automatic test_empty();
    do_reset();
    req = 1'b1; mask = 8'hFF;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if ({ack, fifo_level} !== {1'b0, (e == 3) ? 3'd1 : 3'd0}) begin
        failures++;
        $display("FAIL empty_wait_e%0d got ack=%b lvl=%0d exp ack=0 lvl=%0d", e, ack, fifo_level, (e == 3) ? 1 : 0);
      end else $display("empty wait edge %0d", e);
    end
    tick();  // edge 4
    req = 1'b0;
    checks++;
    if ({ack, rand_byte, fifo_level} !== {1'b1, EMPTY_B, 3'd0}) begin
      failures++;
      $display("FAIL empty_ack got ack=%b byte=%h lvl=%0d exp ack=1 byte=%h lvl=0", ack, rand_byte, fifo_level, EMPTY_B);
    end else $display("empty ack byte=%h", rand_byte);
    tick();  // edge 5
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL empty_after got ack=%b exp ack=0", ack);
    end else $display("empty after ack low");
  endtask

  // req seen on the same edge as a push into an empty FIFO must not bypass.
  task automatic test_no_bypass();
    req = 1'b1; mask = 8'hFF;
    tick();  // edge 6: push, but FSM goes to WAIT
    checks++;
    if ({ack, fifo_level} !== {1'b0, 3'd1}) begin
      failures++;
      $display("FAIL nobypass_e6 got ack=%b lvl=%0d exp ack=0 lvl=1", ack, fifo_level);
    end else $display("nobypass wait");
    tick();  // edge 7
    req = 1'b0;
    checks++;
    if ({ack, rand_byte, fifo_level} !== {1'b1, NOBYP_B, 3'd0}) begin
      failures++;
      $display("FAIL nobypass_ack got ack=%b byte=%h lvl=%0d exp ack=1 byte=%h lvl=0", ack, rand_byte, fifo_level, NOBYP_B);
    end else $display("nobypass ack byte=%h", rand_byte);
    tick();  // edge 8
  endtask

  // Reset pulsed while waiting: request abandoned, decim restarts.
  task automatic test_reset_wait();
    do_reset();
    req = 1'b1; mask = 8'hFF;
    tick();
    tick();
    reset = 1'b1;
    req   = 1'b0;
    tick();
    reset = 1'b0;
    checks++;
    if ({ack, rand_byte, fifo_level} !== {1'b0, 8'h00, 3'd0}) begin
      failures++;
      $display("FAIL rstwait_pulse got ack=%b byte=%h lvl=%0d exp ack=0 byte=00 lvl=0", ack, rand_byte, fifo_level);
    end else $display("rstwait pulse");
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if ({ack, fifo_level} !== {1'b0, (e >= 3) ? 3'd1 : 3'd0}) begin
        failures++;
        $display("FAIL rstwait_e%0d got ack=%b lvl=%0d exp ack=0 lvl=%0d", e, ack, fifo_level, (e >= 3) ? 1 : 0);
      end else $display("rstwait edge %0d lvl=%0d", e, fifo_level);
    end
  endtask

  initial begin
    reset    = 1'b1;
    req      = 1'b0;
    mask     = 8'h00;
    rand_num = 16'hF5D2;  // fold = 8'h27
    test_reset();
    test_fill();
    test_hit();
    test_full_collision();
    test_back_to_back();
    test_empty();
    test_no_bypass();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
